// File: rtl/door_game_ctrl.sv
// door_game_ctrl: game-state sequencer for the two-player door game.
// Runs the round countdown, player door selection, reveal/scoring and
// game-over detection; every output is a register in the pixel clock domain.
// Optional feature macro: RANDOM_DOORS_EN (LFSR-based door selection instead
// of the deterministic round-counter based selection).
module door_game_ctrl #(
  parameter int TICKS_PER_SEC = 25_000_000,
  parameter int ROUND_SECS    = 5,
  parameter int REVEAL_SECS   = 2,
  parameter int START_LIVES   = 3,
  parameter int NUM_DOORS     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_left,
  input  logic       p1_right,
  input  logic       p2_left,
  input  logic       p2_right,
  output logic [1:0] player_1_pos,
  output logic [1:0] player_2_pos,
  output logic [1:0] correct_door_1,
  output logic [1:0] correct_door_2,
  output logic [1:0] p1_lives,
  output logic [1:0] p2_lives,
  output logic       time_up,
  output logic [3:0] secs_left,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROUND  = 2'd1;
  localparam logic [1:0] S_REVEAL = 2'd2;
  localparam logic [1:0] S_OVER   = 2'd3;

  localparam int            PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TICK_MAX   = PW'(TICKS_PER_SEC - 1);
  localparam logic [1:0]    POS_MAX    = 2'(NUM_DOORS - 1);
  localparam logic [3:0]    ROUND_V    = 4'(ROUND_SECS);
  localparam logic [3:0]    REVEAL_V   = 4'(REVEAL_SECS);
  localparam logic [1:0]    LIVES_V    = 2'(START_LIVES);
  localparam logic [8:0]    NDOORS_V   = 9'(NUM_DOORS);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    secs_q, secs_d;
  logic [3:0]    rev_q, rev_d;
  logic [7:0]    round_cnt_q, round_cnt_d;
  logic [1:0]    pos1_q, pos1_d, pos2_q, pos2_d;
  logic [1:0]    door1_q, door1_d, door2_q, door2_d;
  logic [1:0]    lives1_q, lives1_d, lives2_q, lives2_d;
  logic          time_up_q, time_up_d;
  logic          game_over_q, game_over_d;
  logic [1:0]    winner_q, winner_d;
  logic          tick_s;
  logic          enter_round_s;
  logic          new_game_s;
  logic [8:0]    cnt_ext_s;

`ifdef RANDOM_DOORS_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb_s;
  assign lfsr_fb_s = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Free-running Fibonacci LFSR, stepped every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb_s};
    end
  end
`endif

  // Saturating one-step move; opposing pulses in the same cycle cancel
  function automatic logic [1:0] move_pos(input logic [1:0] pos, input logic l, input logic r);
    logic [1:0] res;
    if (l && !r && (pos != 2'd0)) begin
      res = pos - 2'd1;
    end else if (r && !l && (pos != POS_MAX)) begin
      res = pos + 2'd1;
    end else begin
      res = pos;
    end
    return res;
  endfunction

  // A miss costs one life, never going below zero
  function automatic logic [1:0] score(input logic [1:0] lives, input logic hit);
    logic [1:0] res;
    if (!hit && (lives != 2'd0)) begin
      res = lives - 2'd1;
    end else begin
      res = lives;
    end
    return res;
  endfunction

  assign tick_s = (presc_q == TICK_MAX);

  // Next-state logic for the game FSM and all registered outputs
  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    secs_d        = secs_q;
    rev_d         = rev_q;
    round_cnt_d   = round_cnt_q;
    pos1_d        = pos1_q;
    pos2_d        = pos2_q;
    door1_d       = door1_q;
    door2_d       = door2_q;
    lives1_d      = lives1_q;
    lives2_d      = lives2_q;
    time_up_d     = time_up_q;
    game_over_d   = game_over_q;
    winner_d      = winner_q;
    enter_round_s = 1'b0;
    new_game_s    = 1'b0;
    cnt_ext_s     = 9'd0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          enter_round_s = 1'b1;
          new_game_s    = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_ROUND: begin
        if (tick_s) begin
          presc_d = {PW{1'b0}};
        end else begin
          presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
        end
        if (tick_s && (secs_q <= 4'd1)) begin
          // Final second: reveal and score; moves in this cycle are dropped
          secs_d    = 4'd0;
          state_d   = S_REVEAL;
          time_up_d = 1'b1;
          rev_d     = REVEAL_V;
          lives1_d  = score(lives1_q, pos1_q == door1_q);
          lives2_d  = score(lives2_q, pos2_q == door2_q);
        end else begin
          if (tick_s) begin
            secs_d = secs_q - 4'd1;
          end else begin
            secs_d = secs_q;
          end
          pos1_d = move_pos(pos1_q, p1_left, p1_right);
          pos2_d = move_pos(pos2_q, p2_left, p2_right);
        end
      end
      S_REVEAL: begin
        if (tick_s) begin
          presc_d = {PW{1'b0}};
          if (rev_q <= 4'd1) begin
            if ((lives1_q == 2'd0) || (lives2_q == 2'd0)) begin
              state_d     = S_OVER;
              game_over_d = 1'b1;
              winner_d    = {lives1_q == 2'd0, lives2_q == 2'd0};
            end else begin
              enter_round_s = 1'b1;
            end
          end else begin
            rev_d = rev_q - 4'd1;
          end
        end else begin
          presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_round_s) begin
      state_d   = S_ROUND;
      presc_d   = {PW{1'b0}};
      secs_d    = ROUND_V;
      time_up_d = 1'b0;
      if (new_game_s) begin
        round_cnt_d = 8'd1;
        pos1_d      = 2'd0;
        pos2_d      = 2'd0;
        lives1_d    = LIVES_V;
        lives2_d    = LIVES_V;
        winner_d    = 2'b00;
        game_over_d = 1'b0;
      end else begin
        round_cnt_d = round_cnt_q + 8'd1;
      end
      cnt_ext_s = {1'b0, round_cnt_d};
`ifdef RANDOM_DOORS_EN
      door1_d = 2'({5'd0, lfsr_q[3:0]} % NDOORS_V);
      door2_d = 2'({5'd0, lfsr_q[7:4]} % NDOORS_V);
`else
      door1_d = 2'(cnt_ext_s % NDOORS_V);
      door2_d = 2'((cnt_ext_s + 9'd1) % NDOORS_V);
`endif
    end else begin
      cnt_ext_s = 9'd0;
    end
  end

  // State and output registers; reset aborts any round immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      presc_q     <= {PW{1'b0}};
      secs_q      <= ROUND_V;
      rev_q       <= REVEAL_V;
      round_cnt_q <= 8'd0;
      pos1_q      <= 2'd0;
      pos2_q      <= 2'd0;
      door1_q     <= 2'd0;
      door2_q     <= 2'd0;
      lives1_q    <= LIVES_V;
      lives2_q    <= LIVES_V;
      time_up_q   <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      secs_q      <= secs_d;
      rev_q       <= rev_d;
      round_cnt_q <= round_cnt_d;
      pos1_q      <= pos1_d;
      pos2_q      <= pos2_d;
      door1_q     <= door1_d;
      door2_q     <= door2_d;
      lives1_q    <= lives1_d;
      lives2_q    <= lives2_d;
      time_up_q   <= time_up_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign player_1_pos   = pos1_q;
  assign player_2_pos   = pos2_q;
  assign correct_door_1 = door1_q;
  assign correct_door_2 = door2_q;
  assign p1_lives       = lives1_q;
  assign p2_lives       = lives2_q;
  assign time_up        = time_up_q;
  assign secs_left      = secs_q;
  assign game_over      = game_over_q;
  assign winner         = winner_q;

endmodule

// File: tb/tb_door_game_ctrl.sv
// Scoreboard bench for door_game_ctrl: directed stimulus pushes hand-computed
// output snapshots into a queue, a negedge monitor pops and compares them.
module tb_door_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       p1_left = 1'b0, p1_right = 1'b0, p2_left = 1'b0, p2_right = 1'b0;
  logic [1:0] player_1_pos, player_2_pos, correct_door_1, correct_door_2;
  logic [1:0] p1_lives, p2_lives, winner;
  logic       time_up, game_over;
  logic [3:0] secs_left;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [1:0] p1, p2, d1, d2, l1, l2;
    logic       tu;
    logic [3:0] secs;
    logic       go;
    logic [1:0] win;
  } exp_t;

  exp_t sb_q[$];

  door_game_ctrl #(
    .TICKS_PER_SEC(4), .ROUND_SECS(2), .REVEAL_SECS(1), .START_LIVES(3), .NUM_DOORS(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .p1_left(p1_left), .p1_right(p1_right), .p2_left(p2_left), .p2_right(p2_right),
    .player_1_pos(player_1_pos), .player_2_pos(player_2_pos),
    .correct_door_1(correct_door_1), .correct_door_2(correct_door_2),
    .p1_lives(p1_lives), .p2_lives(p2_lives), .time_up(time_up),
    .secs_left(secs_left), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input string f, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s actual=%0h expected=%0h", n, f, act, exp);
    end
  endtask

  // Monitor: compare every pending expectation against the live outputs
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk(e.name, "pos1",   {2'b00, player_1_pos},   {2'b00, e.p1});
      chk(e.name, "pos2",   {2'b00, player_2_pos},   {2'b00, e.p2});
      chk(e.name, "door1",  {2'b00, correct_door_1}, {2'b00, e.d1});
      chk(e.name, "door2",  {2'b00, correct_door_2}, {2'b00, e.d2});
      chk(e.name, "lives1", {2'b00, p1_lives},       {2'b00, e.l1});
      chk(e.name, "lives2", {2'b00, p2_lives},       {2'b00, e.l2});
      chk(e.name, "time_up",   {3'b000, time_up},    {3'b000, e.tu});
      chk(e.name, "secs_left", secs_left,            e.secs);
      chk(e.name, "game_over", {3'b000, game_over},  {3'b000, e.go});
      chk(e.name, "winner",    {2'b00, winner},      {2'b00, e.win});
    end
  end

  task automatic push_exp(input string n, input logic [1:0] p1, input logic [1:0] p2,
                          input logic [1:0] d1, input logic [1:0] d2,
                          input logic [1:0] l1, input logic [1:0] l2, input logic tu,
                          input logic [3:0] s, input logic go, input logic [1:0] w);
    exp_t e;
    e.name = n; e.p1 = p1; e.p2 = p2; e.d1 = d1; e.d2 = d2; e.l1 = l1; e.l2 = l2;
    e.tu = tu; e.secs = s; e.go = go; e.win = w;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step(3);
    push_exp("reset_state", 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 1'b0, 4'd2, 1'b0, 2'b00);
    reset = 1'b1;
    step(3);
    push_exp("idle_hold", 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 1'b0, 4'd2, 1'b0, 2'b00);

    // Round 1: no moves, doors 1/2
    start = 1'b1; step(1); start = 1'b0;
    push_exp("round1_entry", 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 1'b0, 4'd2, 1'b0, 2'b00);
    step(4);
    push_exp("secs_dec", 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 1'b0, 4'd1, 1'b0, 2'b00);
    start = 1'b1; step(1); start = 1'b0;
    step(2);
    push_exp("start_ignored", 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 1'b0, 4'd1, 1'b0, 2'b00);
    step(1);
    push_exp("reveal1", 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 1'b1, 4'd0, 1'b0, 2'b00);
    p1_right = 1'b1; step(1); p1_right = 1'b0;
    step(3);
    push_exp("round2_entry", 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd2, 1'b0, 4'd2, 1'b0, 2'b00);

    // Round 2: P1 walks to door 2, P2 pushes left at 0
    p1_right = 1'b1; p2_left = 1'b1; step(2);
    push_exp("r2_moves", 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd2, 1'b0, 4'd2, 1'b0, 2'b00);
    step(2); p1_right = 1'b0; p2_left = 1'b0;
    push_exp("r2_saturate", 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd2, 1'b0, 4'd1, 1'b0, 2'b00);
    p1_left = 1'b1; p1_right = 1'b1; step(1); p1_left = 1'b0; p1_right = 1'b0;
    push_exp("r2_both_dir", 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd2, 1'b0, 4'd1, 1'b0, 2'b00);
    step(2);
    p1_left = 1'b1; step(1); p1_left = 1'b0;
    push_exp("reveal2_hit", 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd2, 1'b1, 4'd0, 1'b0, 2'b00);
    step(4);
    push_exp("round3_entry", 2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 1'b0, 4'd2, 1'b0, 2'b00);
    step(8);
    push_exp("reveal3", 2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 1'b1, 4'd0, 1'b0, 2'b00);
    step(4);
    push_exp("round4_entry", 2'd2, 2'd0, 2'd1, 2'd2, 2'd1, 2'd1, 1'b0, 4'd2, 1'b0, 2'b00);
    step(8);
    push_exp("reveal4", 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 1'b1, 4'd0, 1'b0, 2'b00);
    step(4);
    push_exp("over_draw", 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 1'b1, 4'd0, 1'b1, 2'b11);
    p2_right = 1'b1; step(6); p2_right = 1'b0;
    push_exp("over_hold", 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 1'b1, 4'd0, 1'b1, 2'b11);

    // Restart from OVER
    start = 1'b1; step(1); start = 1'b0;
    push_exp("restart", 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 1'b0, 4'd2, 1'b0, 2'b00);
    step(8);
    push_exp("reveal5", 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 1'b1, 4'd0, 1'b0, 2'b00);

    // Asynchronous reset in the middle of REVEAL
    step(1);
    #1 reset = 1'b0;
    #1;
    push_exp("reset_mid_reveal", 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 1'b0, 4'd2, 1'b0, 2'b00);
    step(2);
    reset = 1'b1;
    step(2);
    push_exp("idle_after_reset", 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 1'b0, 4'd2, 1'b0, 2'b00);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d expected=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
